ice40_serial_subtractor: RTL and testbench
==========================================

// Module: ice40_serial_subtractor
// PURPOSE
//  Bit-serial unsigned/two's-complement subtractor for iCE40 fabric: DIFF = A - B, one bit per clock.
//  Complements the LUT4+SB_CARRY full-adder cell. Each step is A + ~B + carry, with carry-in 1.
//  Sits behind a valid/ready operand port and a valid/ready result port.
//  Used where area beats throughput, e.g. in address/limit compare paths.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (>= 1)
// PORTS
//  CLK        in   1      single clock; all state updates on rising edge
//  RESET      in   1      synchronous, active-high reset
//  IN_VALID   in   1      operands A/B valid
//  IN_READY   out  1      block can accept operands (IDLE only)
//  A          in   WIDTH  minuend, sampled on accept edge
//  B          in   WIDTH  subtrahend, sampled on accept edge
//  OUT_VALID  out  1      DIFF/BORROW/OVF valid
//  OUT_READY  in   1      consumer takes result
//  DIFF       out  WIDTH  A - B mod 2^WIDTH
//  BORROW     out  1      1 iff A < B (unsigned) = ~final carry
//  OVF        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (sync, RESET=1 at edge): state IDLE; IN_READY=1, OUT_VALID=0, DIFF=0, BORROW=0, OVF=0.
//  - Reset mid-RUN or mid-DONE has the same effect and discards the in-flight op. RESET wins over all inputs.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: IN_READY=1.
//    - Accept edge (IN_VALID=1): load shift regs a_sh=A, b_sh=B. Set carry=1, cnt=0. Go to RUN.
//  - RUN: IN_READY=0, OUT_VALID=0. Each edge:
//    - d = a_sh[0] ^ ~b_sh[0] ^ carry.
//    - carry' = maj(a_sh[0], ~b_sh[0], carry).
//    - Shift d into result MSB. Shift a_sh and b_sh right.
//    - cnt++. Record the carry before the MSB step as c_msb_in.
//    - When cnt reaches WIDTH-1 (the MSB edge): latch BORROW=~carry' and OVF=c_msb_in^carry'. Go to DONE.
//  - Latency: OUT_VALID rises exactly WIDTH edges after the accept edge.
//  - DONE: OUT_VALID=1. DIFF/BORROW/OVF are held stable.
//    - IN_VALID is ignored; IN_READY=0.
//    - Edge with OUT_READY=1: go to IDLE. OUT_VALID falls. Outputs retain their last value.
//  - No same-cycle handoff: throughput is one op per WIDTH+2 cycles at best.
//  - Counter width: $clog2(WIDTH+1).
//  - WIDTH=1: the MSB step is the only step, so both flags latch on that edge.
//  - A/B changing while not in IDLE has no effect.
// STRUCTURE
//  - Package ice40_serial_pkg:
//    - typedef enum {IDLE, RUN, DONE} ser_state_t.
//    - localparam SUB_LUT_INIT = 16'h6969 (XNOR3 of I0,I1,I2 = I0^~I1^I2).
//  - Sub-module serial_sub_cell: combinational 1-bit full-subtractor slice.
//    - ice40_SB_LUT4, LUT_INIT=SUB_LUT_INIT: I0=a, I1=b, I2=cin, I3=0 -> d.
//    - ice40_SB_CARRY: I0=a, I1=~b, CI=cin -> cout.
//  - Top module holds: FSM, counter, shift registers, carry flop, output registers; one cell instance.
// TESTING
//  1. WIDTH=8, A=0x05, B=0x03 -> DIFF=0x02, BORROW=0, OVF=0; OUT_VALID exactly 8 edges after accept.
//  2. A=0x03, B=0x05 -> DIFF=0xFE, BORROW=1, OVF=0.
//  3. A=0x80, B=0x01 -> DIFF=0x7F, BORROW=0, OVF=1; A=0x7F, B=0xFF -> DIFF=0x80, BORROW=1, OVF=1.
//  4. Backpressure: hold OUT_READY=0 for 5 cycles in DONE while driving IN_VALID=1 with new ops.
//     -> outputs stable, IN_READY=0, nothing accepted.
//     -> raise OUT_READY: IDLE next edge, then next op accepted.
//  5. Assert RESET on the 3rd RUN edge -> next cycle IDLE, OUT_VALID=0, DIFF=0, BORROW=0, OVF=0.
//     -> then A=0xFF, B=0xFF -> DIFF=0x00, BORROW=0, OVF=0.
//  6. WIDTH=1: 1-0 -> DIFF=1, BORROW=0, OVF=0; 0-1 -> DIFF=1, BORROW=1, OVF=1; 1 edge latency.

Source files
------------

// File: rtl/ice40_serial_pkg.sv
// Shared types and constants for the bit-serial iCE40 subtractor.
package ice40_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // XNOR3 of I0,I1,I2: I0 ^ ~I1 ^ I2, independent of I3
    localparam logic [15:0] SUB_LUT_INIT = 16'h6969;

endpackage

// File: rtl/ice40_serial_subtractor_cell.sv
// One-bit full-subtractor slice built from behavioural models of the
// iCE40 LUT4 and carry-chain primitives.
module ice40_SB_LUT4 #(
    parameter logic [15:0] LUT_INIT = 16'h0000
) (
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    output logic O
);
    assign O = LUT_INIT[{I3, I2, I1, I0}];
endmodule

module ice40_SB_CARRY (
    input  logic I0,
    input  logic I1,
    input  logic CI,
    output logic CO
);
    assign CO = (I0 & I1) | (I0 & CI) | (I1 & CI);
endmodule

module serial_sub_cell
    import ice40_serial_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic cout
);
    logic b_n;

    assign b_n = ~b;

    // The LUT inverts b internally; the carry cell needs it inverted explicitly.
    ice40_SB_LUT4 #(.LUT_INIT(SUB_LUT_INIT)) u_lut (
        .I0 (a),
        .I1 (b),
        .I2 (cin),
        .I3 (1'b0),
        .O  (d)
    );

    ice40_SB_CARRY u_carry (
        .I0 (a),
        .I1 (b_n),
        .CI (cin),
        .CO (cout)
    );
endmodule

// File: rtl/ice40_serial_subtractor.sv
// Bit-serial subtractor DIFF = A - B, LSB first, one bit per clock,
// with valid/ready handshakes on operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, IN_READY=1
// RUN   | one difference bit per edge, LSB first
// DONE  | result held with OUT_VALID=1 until OUT_READY
module ice40_serial_subtractor
    import ice40_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVF
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] next_res;
    logic             carry;
    logic             d;
    logic             cout;

    serial_sub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .d    (d),
        .cout (cout)
    );

    always_comb begin
        next_res            = res >> 1;
        next_res[WIDTH-1]   = d;
    end

    assign IN_READY  = (state == ST_IDLE);
    assign OUT_VALID = (state == ST_DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            DIFF   <= '0;
            BORROW <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= next_res;
                    carry <= cout;
                    cnt   <= cnt + CW'(1);
                    // On the MSB step the current carry is the carry into the MSB.
                    if (cnt == CNT_LAST) begin
                        DIFF   <= next_res;
                        BORROW <= ~cout;
                        OVF    <= carry ^ cout;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ice40_serial_subtractor.sv
// Directed-vector bench for the serial subtractor at WIDTH=8 and WIDTH=1.
module tb_ice40_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       iv8, ir8, ov8, or8;
    logic [7:0] a8, b8, d8;
    logic       bo8, of8;
    logic       iv1, ir1, ov1, or1;
    logic [0:0] a1, b1, d1;
    logic       bo1, of1;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] held;

    always #5 clk = ~clk;

    ice40_serial_subtractor #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET(rst), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
        .OUT_VALID(ov8), .OUT_READY(or8), .DIFF(d8), .BORROW(bo8), .OVF(of8)
    );

    ice40_serial_subtractor #(.WIDTH(1)) dut1 (
        .CLK(clk), .RESET(rst), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
        .OUT_VALID(ov1), .OUT_READY(or1), .DIFF(d1), .BORROW(bo1), .OVF(of1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operand pair, wait for OUT_VALID with a bound, check latency and result.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        a8 = a; b8 = b; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk({tag, "_in_ready_low"}, 32'(ir8), 32'd0);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ov8) begin n = i; break; end
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_diff"}, 32'(d8), 32'(ed));
        chk({tag, "_borrow"}, 32'(bo8), 32'(eb));
        chk({tag, "_ovf"}, 32'(of8), 32'(eo));
    endtask

    task automatic release8(input string tag);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk({tag, "_out_valid_fall"}, 32'(ov8), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(ir8), 32'd1);
    endtask

    task automatic run1(input string tag, input logic a, input logic b,
                        input logic ed, input logic eb, input logic eo);
        a1 = a; b1 = b; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        tick();
        chk({tag, "_out_valid_1edge"}, 32'(ov1), 32'd1);
        chk({tag, "_diff"}, 32'(d1), 32'(ed));
        chk({tag, "_borrow"}, 32'(bo1), 32'(eb));
        chk({tag, "_ovf"}, 32'(of1), 32'(eo));
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        chk({tag, "_idle"}, 32'(ir1), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_borrow", 32'(bo8), 32'd0);
        chk("rst_ovf", 32'(of8), 32'd0);

        run8("t1_05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        release8("t1");
        run8("t2_03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        release8("t2");
        run8("t3_80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        release8("t3a");
        run8("t3_7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        release8("t3b");
        run8("tx_7Fm80", 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1);
        release8("tx");

        // Backpressure: result held while new operands are offered.
        run8("t4_3Cm0F", 8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0);
        a8 = 8'h10; b8 = 8'h20; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 32'(ov8), 32'd1);
            chk("t4_hold_in_ready", 32'(ir8), 32'd0);
            chk("t4_hold_diff", 32'(d8), 32'h2D);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("t4_idle_out_valid", 32'(ov8), 32'd0);
        chk("t4_idle_in_ready", 32'(ir8), 32'd1);
        chk("t4_idle_diff_kept", 32'(d8), 32'h2D);
        tick();
        iv8 = 1'b0;
        chk("t4_next_accepted", 32'(ir8), 32'd0);
        held = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (ov8) break;
            tick();
        end
        chk("t4_next_valid", 32'(ov8), 32'd1);
        chk("t4_next_diff", 32'(d8), 32'hF0);
        chk("t4_next_borrow", 32'(bo8), 32'd1);
        chk("t4_next_ovf", 32'(of8), 32'd0);
        release8("t4");

        // Reset on the third RUN edge discards the operation.
        a8 = 8'h12; b8 = 8'h34; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_in_ready", 32'(ir8), 32'd1);
        chk("t5_rst_out_valid", 32'(ov8), 32'd0);
        chk("t5_rst_diff", 32'(d8), 32'd0);
        chk("t5_rst_borrow", 32'(bo8), 32'd0);
        chk("t5_rst_ovf", 32'(of8), 32'd0);
        run8("t5_FFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        release8("t5");

        run1("t6_1m0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1("t6_0m1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
